// File: rtl/updown_pkg.sv
// Shared definitions for the bounce controller and the 4-bit up/down counter it steers.
// Keeps the state encoding and direction levels in one place.
package updown_pkg;

  localparam int CNT_W = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } state_e;

  // Integer compare keeps the degenerate LO=0 / HI=15 cases free of constant-compare noise.
  function automatic logic in_range(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// BW-bit event counter: increments on inc_i, sticks at all-ones, synchronous zero on clr_i.
// Asynchronous active-low reset to zero.
module sat_counter #(
  parameter int BW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [BW-1:0] cnt_o
);

  logic [BW-1:0] cnt_q, cnt_d;

  // Clear wins over increment so a restart never inherits a pending count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/updown_bounce_ctrl.sv
// Closed-loop direction controller: steers an up/down counter so its count ping-pongs
// between LO and HI, counts reversals and flags loss of tracking.
module updown_bounce_ctrl
  import updown_pkg::*;
#(
  parameter int LO = 2,
  parameter int HI = 6,
  parameter int BW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] count_in,
  output logic             cntrl,
  output logic             clr,
  output logic             turn,
  output logic [BW-1:0]    bounces,
  output logic             err
);

  if ((LO < 0) || (HI > 15) || ((HI - LO) < 2)) begin : g_bad_bounds
    $error("updown_bounce_ctrl: bounds must satisfy 0 <= LO, LO+2 <= HI <= 15");
  end

  // Reversal is decided one count early because the counter moves on the same edge.
  localparam logic [CNT_W-1:0] LO_C       = CNT_W'(LO);
  localparam logic [CNT_W-1:0] TURN_DN_AT = CNT_W'(HI - 1);
  localparam logic [CNT_W-1:0] TURN_UP_AT = CNT_W'(LO + 1);

  state_e state_q, state_d;
  logic   cntrl_q, cntrl_d;
  logic   clr_q,   clr_d;
  logic   turn_q,  turn_d;
  logic   err_q,   err_d;
  logic   bnc_clr, bnc_inc;

  always_comb begin
    state_d = state_q;
    cntrl_d = cntrl_q;
    clr_d   = clr_q;
    turn_d  = 1'b0;
    err_d   = err_q;
    bnc_clr = 1'b0;
    bnc_inc = 1'b0;

    case (state_q)
      IDLE: begin
        clr_d   = 1'b1;
        cntrl_d = DIR_UP;
        if (en) begin
          state_d = ALIGN;
          clr_d   = 1'b0;
          err_d   = 1'b0;
          bnc_clr = 1'b1;
        end
      end

      default: begin
        if (!en) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          cntrl_d = DIR_UP;
        end else if (state_q == ALIGN) begin
          if (count_in == LO_C) begin
            state_d = UP;
          end
        end else if (!in_range(count_in, LO, HI)) begin
          // Counter escaped the window: park it cleared and latch the fault.
          state_d = IDLE;
          err_d   = 1'b1;
          clr_d   = 1'b1;
          cntrl_d = DIR_UP;
        end else if ((state_q == UP) && (count_in == TURN_DN_AT)) begin
          state_d = DOWN;
          cntrl_d = DIR_DN;
          turn_d  = 1'b1;
          bnc_inc = 1'b1;
        end else if ((state_q == DOWN) && (count_in == TURN_UP_AT)) begin
          state_d = UP;
          cntrl_d = DIR_UP;
          turn_d  = 1'b1;
          bnc_inc = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cntrl_q <= DIR_UP;
      clr_q   <= 1'b1;
      turn_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cntrl_q <= cntrl_d;
      clr_q   <= clr_d;
      turn_q  <= turn_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .BW(BW)
  ) u_bounces (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (bnc_clr),
    .inc_i (bnc_inc),
    .cnt_o (bounces)
  );

  assign cntrl = cntrl_q;
  assign clr   = clr_q;
  assign turn  = turn_q;
  assign err   = err_q;

endmodule

// File: tb/tb_updown_bounce_ctrl.sv
// Closed-loop bench: two controllers (default and extreme bounds) each driving a counter
// model, checked every cycle against a behavioural model plus directed literal checks.
module tb_updown_bounce_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b, force_a;
  logic [3:0] cnt_a = 4'd0;
  logic [3:0] cnt_b = 4'd0;
  logic [3:0] cin_a, cin_b;
  logic       cntrl_a, clr_a, turn_a, err_a;
  logic       cntrl_b, clr_b, turn_b, err_b;
  logic [7:0] bounces_a;
  logic [1:0] bounces_b;

  int  errors = 0;
  int  total  = 0;
  bit  run_cmp = 1'b0;

  always #5 clk = ~clk;

  assign cin_a = force_a ? 4'd9 : cnt_a;
  assign cin_b = cnt_b;

  updown_bounce_ctrl #(.LO(2), .HI(6), .BW(8)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .count_in(cin_a),
    .cntrl(cntrl_a), .clr(clr_a), .turn(turn_a), .bounces(bounces_a), .err(err_a)
  );

  updown_bounce_ctrl #(.LO(0), .HI(15), .BW(2)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .count_in(cin_b),
    .cntrl(cntrl_b), .clr(clr_b), .turn(turn_b), .bounces(bounces_b), .err(err_b)
  );

  // The counters being steered: clear, else step in the commanded direction.
  always @(posedge clk) begin
    cnt_a <= clr_a ? 4'd0 : (cntrl_a ? cnt_a + 4'd1 : cnt_a - 4'd1);
    cnt_b <= clr_b ? 4'd0 : (cntrl_b ? cnt_b + 4'd1 : cnt_b - 4'd1);
  end

  // Behavioural model: running/aligned/heading-up flags plus expected output levels.
  typedef struct {
    bit running;
    bit aligned;
    bit heading_up;
    bit cntrl;
    bit clr;
    bit turn;
    bit err;
    int bounces;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.running = 0; m.aligned = 0; m.heading_up = 1;
    m.cntrl = 1; m.clr = 1; m.turn = 0; m.err = 0; m.bounces = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int lo, int hi, int bmax, bit en, int c);
    mdl_t n = m;
    n.turn = 0;
    if (!m.running) begin
      n.clr = 1; n.cntrl = 1;
      if (en) begin
        n.running = 1; n.aligned = 0; n.clr = 0; n.bounces = 0; n.err = 0;
      end
    end else if (!en) begin
      n.running = 0; n.clr = 1; n.cntrl = 1;
    end else if (!m.aligned) begin
      if (c == lo) begin n.aligned = 1; n.heading_up = 1; end
    end else if (c < lo || c > hi) begin
      n.running = 0; n.err = 1; n.clr = 1; n.cntrl = 1;
    end else if (m.heading_up && c == hi - 1) begin
      n.heading_up = 0; n.cntrl = 0; n.turn = 1;
      n.bounces = (m.bounces < bmax) ? m.bounces + 1 : bmax;
    end else if (!m.heading_up && c == lo + 1) begin
      n.heading_up = 1; n.cntrl = 1; n.turn = 1;
      n.bounces = (m.bounces < bmax) ? m.bounces + 1 : bmax;
    end
    return n;
  endfunction

  mdl_t ma, mb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= mdl_reset();
      mb <= mdl_reset();
    end else begin
      ma <= mdl_step(ma, 2, 6, 255, en_a, int'(cin_a));
      mb <= mdl_step(mb, 0, 15, 3, en_b, int'(cin_b));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    errors++;
    $display("FAIL %s: wait expired (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("a_cntrl",   int'(cntrl_a),   int'(ma.cntrl));
      chk("a_clr",     int'(clr_a),     int'(ma.clr));
      chk("a_turn",    int'(turn_a),    int'(ma.turn));
      chk("a_bounces", int'(bounces_a), ma.bounces);
      chk("a_err",     int'(err_a),     int'(ma.err));
      chk("b_cntrl",   int'(cntrl_b),   int'(mb.cntrl));
      chk("b_clr",     int'(clr_b),     int'(mb.clr));
      chk("b_turn",    int'(turn_b),    int'(mb.turn));
      chk("b_bounces", int'(bounces_b), mb.bounces);
      chk("b_err",     int'(err_b),     int'(mb.err));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int expc;
    en_a = 0; en_b = 0; force_a = 0; rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_cntrl",   int'(cntrl_a),   1);
    chk("rst_clr",     int'(clr_a),     1);
    chk("rst_turn",    int'(turn_a),    0);
    chk("rst_bounces", int'(bounces_a), 0);
    chk("rst_err",     int'(err_a),     0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_cmp = 1'b1;
    repeat (2) @(negedge clk);

    // Closed-loop bounce between 2 and 6.
    en_a = 1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      expc = (i <= 6) ? i : (i <= 10) ? 12 - i : (i <= 14) ? i - 8 : 20 - i;
      chk("seq_count", int'(cnt_a), expc);
      if (i == 6 || i == 10 || i == 14 || i == 18) chk("seq_turn", int'(turn_a), 1);
      if (i == 10) chk("seq_bounces2", int'(bounces_a), 2);
      if (i == 18) chk("seq_bounces4", int'(bounces_a), 4);
    end

    // Drop en in UP at count 4.
    t = 0;
    while (!(cnt_a == 4'd4 && cntrl_a == 1'b1) && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) timeout("wait_up4");
    en_a = 0;
    @(negedge clk);
    chk("hold_clr", int'(clr_a), 1);
    chk("hold_count", int'(cnt_a), 5);
    chk("hold_bounces", int'(bounces_a), 4);
    @(negedge clk);
    chk("hold_count0", int'(cnt_a), 0);
    chk("hold_bounces2", int'(bounces_a), 4);
    en_a = 1;
    @(negedge clk);
    chk("restart_bounces", int'(bounces_a), 0);
    chk("restart_clr", int'(clr_a), 0);
    chk("restart_count", int'(cnt_a), 0);
    @(negedge clk);
    chk("restart_count1", int'(cnt_a), 1);

    // Out-of-window count while heading down.
    t = 0;
    while (!(cnt_a == 4'd4 && cntrl_a == 1'b0) && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) timeout("wait_down4");
    force_a = 1;
    @(negedge clk);
    chk("fault_err", int'(err_a), 1);
    chk("fault_clr", int'(clr_a), 1);
    chk("fault_cntrl", int'(cntrl_a), 1);
    force_a = 0;
    en_a = 0;
    repeat (3) begin
      @(negedge clk);
      chk("fault_sticky", int'(err_a), 1);
    end
    en_a = 1;
    @(negedge clk);
    chk("fault_cleared", int'(err_a), 0);
    chk("fault_run_clr", int'(clr_a), 0);

    // Asynchronous reset pulse mid-DOWN.
    t = 0;
    while (!(cnt_a == 4'd3 && cntrl_a == 1'b0) && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) timeout("wait_down3");
    #1 rst = 1'b0;
    #1;
    chk("arst_cntrl",   int'(cntrl_a),   1);
    chk("arst_clr",     int'(clr_a),     1);
    chk("arst_bounces", int'(bounces_a), 0);
    chk("arst_err",     int'(err_a),     0);
    chk("arst_turn",    int'(turn_a),    0);
    #2 rst = 1'b1;
    repeat (12) @(negedge clk);
    en_a = 0;
    repeat (3) @(negedge clk);

    // Full-range bounce with a 2-bit reversal counter.
    en_b = 1;
    for (int i = 0; i <= 60; i++) begin
      @(negedge clk);
      expc = (i <= 15) ? i : (i <= 30) ? 30 - i : (i <= 45) ? i - 30 : 60 - i;
      chk("wide_count", int'(cnt_b), expc);
      if (i == 15 || i == 30 || i == 45 || i == 60) chk("wide_turn", int'(turn_b), 1);
      if (i == 15) chk("wide_bounces1", int'(bounces_b), 1);
      if (i == 45) chk("wide_bounces3", int'(bounces_b), 3);
      if (i == 60) chk("wide_sat", int'(bounces_b), 3);
    end
    chk("wide_err", int'(err_b), 0);
    en_b = 0;
    repeat (2) @(negedge clk);

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
